// File: rtl/color_id_pkg.sv
// rtl/color_id_pkg.sv - shared constants, threshold-word layout, FSM states and helpers for color_identify_mc
package color_id_pkg;

  localparam int THR_W      = 32;
  localparam int MAX_COLORS = 8;
  localparam int CONF_W     = 4;

  localparam int R_W = 5;
  localparam int G_W = 6;
  localparam int B_W = 5;

  // Word layout, MSB first: {r_min, r_max, g_min, g_max, b_min, b_max}
  localparam int R_MIN_LSB = 27;
  localparam int R_MAX_LSB = 22;
  localparam int G_MIN_LSB = 16;
  localparam int G_MAX_LSB = 10;
  localparam int B_MIN_LSB = 5;
  localparam int B_MAX_LSB = 0;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    LATCH  = 2'd2
  } fsm_state_t;

  function automatic logic [THR_W-1:0] thr_word(input logic [MAX_COLORS*THR_W-1:0] bus,
                                                input int c);
    return bus[c*THR_W +: THR_W];
  endfunction

endpackage

// File: rtl/color_px_match.sv
// rtl/color_px_match.sv - combinational RGB565 inclusive min/max box test against one threshold word
module color_px_match
  import color_id_pkg::*;
(
  input  logic [15:0]      i_pixel,
  input  logic [THR_W-1:0] i_thr,
  output logic             o_match
);

  logic [R_W-1:0] w_r;
  logic [G_W-1:0] w_g;
  logic [B_W-1:0] w_b;
  logic [R_W-1:0] w_r_min;
  logic [R_W-1:0] w_r_max;
  logic [G_W-1:0] w_g_min;
  logic [G_W-1:0] w_g_max;
  logic [B_W-1:0] w_b_min;
  logic [B_W-1:0] w_b_max;
  logic           w_r_ok;
  logic           w_g_ok;
  logic           w_b_ok;

  assign w_r = i_pixel[15:11];
  assign w_g = i_pixel[10:5];
  assign w_b = i_pixel[4:0];

  assign w_r_min = i_thr[R_MIN_LSB +: R_W];
  assign w_r_max = i_thr[R_MAX_LSB +: R_W];
  assign w_g_min = i_thr[G_MIN_LSB +: G_W];
  assign w_g_max = i_thr[G_MAX_LSB +: G_W];
  assign w_b_min = i_thr[B_MIN_LSB +: B_W];
  assign w_b_max = i_thr[B_MAX_LSB +: B_W];

  // A field with min > max can never satisfy both bounds, so it never matches.
  assign w_r_ok = (w_r >= w_r_min) && (w_r <= w_r_max);
  assign w_g_ok = (w_g >= w_g_min) && (w_g <= w_g_max);
  assign w_b_ok = (w_b >= w_b_min) && (w_b <= w_b_max);

  assign o_match = w_r_ok && w_g_ok && w_b_ok;

endmodule

// File: rtl/color_identify_mc.sv
// rtl/color_identify_mc.sv - multi-colour RGB565 frame classifier with confirmation filter
// Define COLOR_ID_DOMINANT_EN to build the dominant-colour comparator (dom_idx/dom_valid).
module color_identify_mc
  import color_id_pkg::*;
#(
  parameter int NUM_COLORS     = 4,
  parameter int CNT_W          = 20,
  parameter int CONFIRM_FRAMES = 3
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        per_frame_vsync,
  input  logic                        per_frame_href,
  input  logic                        per_frame_clken,
  input  logic [15:0]                 img_data,
  input  logic [NUM_COLORS*THR_W-1:0] cfg_thr,
  input  logic [CNT_W-1:0]            cfg_min_pix,
  output logic                        post_frame_vsync,
  output logic                        post_frame_href,
  output logic                        post_frame_clken,
  output logic [NUM_COLORS-1:0]       post_pix_hit,
  output logic                        color_valid,
  output logic [NUM_COLORS-1:0]       color_hit,
  output logic [NUM_COLORS-1:0]       color_conf,
  output logic                        img_en,
  output logic [2:0]                  dom_idx,
  output logic                        dom_valid
);

  localparam logic [CNT_W-1:0]  CNT_MAX  = '1;
  localparam logic [CONF_W-1:0] CONF_TOP = CONF_W'(CONFIRM_FRAMES);

  fsm_state_t                  r_state;
  logic                        r_vsync_d;
  logic [NUM_COLORS*THR_W-1:0] r_shadow_thr;
  logic [CNT_W-1:0]            r_shadow_min;
  logic [CNT_W-1:0]            r_snap_min;
  logic [CNT_W-1:0]            r_cnt      [NUM_COLORS];
  logic [CNT_W-1:0]            r_snap     [NUM_COLORS];
  logic [CONF_W-1:0]           r_conf_cnt [NUM_COLORS];

  logic [MAX_COLORS*THR_W-1:0] w_thr_ext;
  logic [NUM_COLORS-1:0]       w_match;
  logic                        w_boundary;
  logic [CNT_W-1:0]            w_cnt_inc   [NUM_COLORS];
  logic [CNT_W-1:0]            w_cnt_first [NUM_COLORS];
  logic [CONF_W-1:0]           w_conf_next [NUM_COLORS];
  logic [NUM_COLORS-1:0]       w_hit_next;
  logic [NUM_COLORS-1:0]       w_conf_flag;

  always_comb begin
    w_thr_ext = '0;
    w_thr_ext[NUM_COLORS*THR_W-1:0] = r_shadow_thr;
  end

  // Matching uses the shadow thresholds, so mid-frame cfg_thr writes wait for the next boundary.
  for (genvar c = 0; c < NUM_COLORS; c++) begin : g_match
    logic [THR_W-1:0] w_thr;
    assign w_thr = thr_word(w_thr_ext, c);
    color_px_match u_match (
      .i_pixel (img_data),
      .i_thr   (w_thr),
      .o_match (w_match[c])
    );
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      post_frame_vsync <= 1'b0;
      post_frame_href  <= 1'b0;
      post_frame_clken <= 1'b0;
      post_pix_hit     <= '0;
      r_vsync_d        <= 1'b0;
    end else begin
      post_frame_vsync <= per_frame_vsync;
      post_frame_href  <= per_frame_href;
      post_frame_clken <= per_frame_clken;
      post_pix_hit     <= w_match & {NUM_COLORS{per_frame_href & per_frame_clken}};
      r_vsync_d        <= post_frame_vsync;
    end
  end

  assign w_boundary = post_frame_vsync & ~r_vsync_d;

  always_comb begin
    for (int c = 0; c < NUM_COLORS; c++) begin
      w_cnt_first[c] = CNT_W'(post_pix_hit[c]);
      w_cnt_inc[c]   = (r_cnt[c] == CNT_MAX) ? r_cnt[c] : r_cnt[c] + CNT_W'(post_pix_hit[c]);
      w_hit_next[c]  = (r_snap[c] >= r_snap_min);
    end
  end

  always_comb begin
    for (int c = 0; c < NUM_COLORS; c++) begin
      if (!w_hit_next[c]) begin
        w_conf_next[c] = '0;
      end else if (r_conf_cnt[c] == CONF_TOP) begin
        w_conf_next[c] = r_conf_cnt[c];
      end else begin
        w_conf_next[c] = r_conf_cnt[c] + 1'b1;
      end
      w_conf_flag[c] = (w_conf_next[c] == CONF_TOP);
    end
  end

  // The pixel reported on the boundary cycle opens the new frame, hence counters reload rather than clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= IDLE;
      r_shadow_thr <= '0;
      r_shadow_min <= '0;
      r_snap_min   <= '0;
      color_valid  <= 1'b0;
      color_hit    <= '0;
      color_conf   <= '0;
      img_en       <= 1'b0;
      for (int c = 0; c < NUM_COLORS; c++) begin
        r_cnt[c]      <= '0;
        r_snap[c]     <= '0;
        r_conf_cnt[c] <= '0;
      end
    end else begin
      color_valid <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_boundary) begin
            r_state      <= ACTIVE;
            r_shadow_thr <= cfg_thr;
            r_shadow_min <= cfg_min_pix;
            for (int c = 0; c < NUM_COLORS; c++) begin
              r_cnt[c] <= w_cnt_first[c];
            end
          end
        end
        ACTIVE: begin
          if (w_boundary) begin
            r_state      <= LATCH;
            r_snap_min   <= r_shadow_min;
            r_shadow_thr <= cfg_thr;
            r_shadow_min <= cfg_min_pix;
            for (int c = 0; c < NUM_COLORS; c++) begin
              r_snap[c] <= r_cnt[c];
              r_cnt[c]  <= w_cnt_first[c];
            end
          end else begin
            for (int c = 0; c < NUM_COLORS; c++) begin
              r_cnt[c] <= w_cnt_inc[c];
            end
          end
        end
        LATCH: begin
          r_state     <= ACTIVE;
          color_valid <= 1'b1;
          color_hit   <= w_hit_next;
          color_conf  <= w_conf_flag;
          img_en      <= |w_conf_flag;
          for (int c = 0; c < NUM_COLORS; c++) begin
            r_cnt[c]      <= w_cnt_inc[c];
            r_conf_cnt[c] <= w_conf_next[c];
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

`ifdef COLOR_ID_DOMINANT_EN
  logic [2:0]       w_dom_idx;
  logic [CNT_W-1:0] w_dom_cnt;

  // Strict greater-than keeps the lowest index on ties.
  always_comb begin
    w_dom_idx = '0;
    w_dom_cnt = r_snap[0];
    for (int c = 1; c < NUM_COLORS; c++) begin
      if (r_snap[c] > w_dom_cnt) begin
        w_dom_cnt = r_snap[c];
        w_dom_idx = 3'(c);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dom_idx   <= '0;
      dom_valid <= 1'b0;
    end else if (r_state == LATCH) begin
      dom_idx   <= w_dom_idx;
      dom_valid <= (w_dom_cnt != '0);
    end
  end
`else
  assign dom_idx   = '0;
  assign dom_valid = 1'b0;
`endif

endmodule

// File: tb/tb_color_identify_mc.sv
// tb/tb_color_identify_mc.sv - self-checking bench for color_identify_mc (table, scenarios, random frames)
module tb_color_identify_mc;

  localparam int NC = 2;
  localparam int CW = 20;
  localparam int CF = 3;

`ifdef COLOR_ID_DOMINANT_EN
  localparam bit DOM_EN = 1'b1;
`else
  localparam bit DOM_EN = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            rst;
  logic            per_frame_vsync;
  logic            per_frame_href;
  logic            per_frame_clken;
  logic [15:0]     img_data;
  logic [NC*32-1:0] cfg_thr;
  logic [CW-1:0]   cfg_min_pix;
  logic            post_frame_vsync;
  logic            post_frame_href;
  logic            post_frame_clken;
  logic [NC-1:0]   post_pix_hit;
  logic            color_valid;
  logic [NC-1:0]   color_hit;
  logic [NC-1:0]   color_conf;
  logic            img_en;
  logic [2:0]      dom_idx;
  logic            dom_valid;

  color_identify_mc #(
    .NUM_COLORS     (NC),
    .CNT_W          (CW),
    .CONFIRM_FRAMES (CF)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .per_frame_vsync  (per_frame_vsync),
    .per_frame_href   (per_frame_href),
    .per_frame_clken  (per_frame_clken),
    .img_data         (img_data),
    .cfg_thr          (cfg_thr),
    .cfg_min_pix      (cfg_min_pix),
    .post_frame_vsync (post_frame_vsync),
    .post_frame_href  (post_frame_href),
    .post_frame_clken (post_frame_clken),
    .post_pix_hit     (post_pix_hit),
    .color_valid      (color_valid),
    .color_hit        (color_hit),
    .color_conf       (color_conf),
    .img_en           (img_en),
    .dom_idx          (dom_idx),
    .dom_valid        (dom_valid)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: frame-level bookkeeping in plain integers
  bit              m_armed;
  logic [NC*32-1:0] m_thr;
  int              m_min;
  int              m_cnt  [NC];
  int              m_conf [NC];
  logic [NC-1:0]   m_o_hit;
  logic [NC-1:0]   m_o_conf;
  logic            m_o_img;
  logic [2:0]      m_o_dom;
  logic            m_o_domv;
  logic [15:0]     fq [$];

  typedef struct {
    logic [15:0]   pix;
    logic [NC-1:0] hit;
  } vec_t;
  vec_t tbl [12];

  function automatic logic [15:0] pix(input int r, input int g, input int b);
    return 16'(r * 2048 + g * 32 + b);
  endfunction

  function automatic logic [31:0] mk_thr(input int rmin, input int rmax, input int gmin,
                                         input int gmax, input int bmin, input int bmax);
    return {5'(rmin), 5'(rmax), 6'(gmin), 6'(gmax), 5'(bmin), 5'(bmax)};
  endfunction

  function automatic bit box_match(input logic [15:0] p, input logic [31:0] w);
    int r, g, b;
    r = int'(p) / 2048;
    g = (int'(p) / 32) % 64;
    b = int'(p) % 32;
    return (int'((w >> 27) & 32'd31) <= r) && (r <= int'((w >> 22) & 32'd31)) &&
           (int'((w >> 16) & 32'd63) <= g) && (g <= int'((w >> 10) & 32'd63)) &&
           (int'((w >> 5)  & 32'd31) <= b) && (b <= int'(w & 32'd31));
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    m_armed  = 1'b0;
    m_thr    = '0;
    m_min    = 0;
    m_o_hit  = '0;
    m_o_conf = '0;
    m_o_img  = 1'b0;
    m_o_dom  = '0;
    m_o_domv = 1'b0;
    for (int c = 0; c < NC; c++) begin
      m_cnt[c]  = 0;
      m_conf[c] = 0;
    end
  endtask

  task automatic check_outs(input string tag);
    check({tag, "_color_hit"}, 32'(color_hit), 32'(m_o_hit));
    check({tag, "_color_conf"}, 32'(color_conf), 32'(m_o_conf));
    check({tag, "_img_en"}, 32'(img_en), 32'(m_o_img));
    check({tag, "_dom_idx"}, 32'(dom_idx), 32'(m_o_dom));
    check({tag, "_dom_valid"}, 32'(dom_valid), 32'(m_o_domv));
  endtask

  task automatic drive_cycle(input logic vs, input logic hr, input logic ck, input logic [15:0] p);
    logic [NC-1:0] e_hit;
    per_frame_vsync = vs;
    per_frame_href  = hr;
    per_frame_clken = ck;
    img_data        = p;
    for (int c = 0; c < NC; c++) e_hit[c] = hr && ck && box_match(p, m_thr[c*32 +: 32]);
    tick();
    check("post_pix_hit", 32'(post_pix_hit), 32'(e_hit));
    check("post_sync", 32'({post_frame_vsync, post_frame_href, post_frame_clken}), 32'({vs, hr, ck}));
    if (hr && ck) for (int c = 0; c < NC; c++) m_cnt[c] += int'(e_hit[c]);
  endtask

  task automatic fill(input logic [15:0] p, input int n);
    repeat (n) fq.push_back(p);
  endtask

  task automatic run_frame(input bit chg, input logic [CW-1:0] nmin, input logic [NC*32-1:0] nthr);
    drive_cycle(1'b0, 1'b0, 1'b0, 16'($urandom));
    drive_cycle(1'b0, 1'b0, 1'b0, 16'($urandom));
    for (int i = 0; i < fq.size(); i++) begin
      if ($urandom_range(3) == 0) drive_cycle(1'b0, 1'b1, 1'b0, 16'($urandom));
      drive_cycle(1'b0, 1'b1, 1'b1, fq[i]);
      if (chg && i == 15) begin
        cfg_min_pix = nmin;
        cfg_thr     = nthr;
      end
      if (i % 8 == 7) drive_cycle(1'b0, 1'b0, 1'b0, 16'($urandom));
    end
    drive_cycle(1'b0, 1'b0, 1'b0, 16'($urandom));
    fq.delete();
  endtask

  task automatic boundary();
    int lat    = 0;
    int pulses = 0;
    int best;
    bit was_armed = m_armed;
    if (m_armed) begin
      for (int c = 0; c < NC; c++) begin
        m_o_hit[c] = (m_cnt[c] >= m_min);
        m_conf[c]  = m_o_hit[c] ? ((m_conf[c] < CF) ? m_conf[c] + 1 : CF) : 0;
        m_o_conf[c] = (m_conf[c] == CF);
      end
      m_o_img = |m_o_conf;
      best = 0;
      for (int c = 1; c < NC; c++) if (m_cnt[c] > m_cnt[best]) best = c;
      m_o_dom  = DOM_EN ? 3'(best) : 3'd0;
      m_o_domv = DOM_EN && (m_cnt[best] > 0);
    end
    for (int i = 1; i <= 6; i++) begin
      drive_cycle(1'b1, 1'b0, 1'b0, 16'($urandom));
      if (color_valid) begin
        pulses++;
        if (lat == 0) lat = i;
      end
    end
    check("valid_pulses", 32'(pulses), was_armed ? 32'd1 : 32'd0);
    if (was_armed) check("valid_latency", 32'(lat), 32'd3);
    check_outs("frame");
    m_armed = 1'b1;
    m_thr   = cfg_thr;
    m_min   = int'(cfg_min_pix);
    for (int c = 0; c < NC; c++) m_cnt[c] = 0;
  endtask

  logic [31:0] c0_thr;
  logic [31:0] c1_thr;

  initial begin
    c0_thr = mk_thr(0, 3, 0, 7, 28, 31);
    c1_thr = mk_thr(10, 14, 30, 40, 26, 31);

    tbl[0]  = '{16'h001F,         2'b01};
    tbl[1]  = '{pix(12, 37, 29),  2'b10};
    tbl[2]  = '{16'd100,          2'b00};
    tbl[3]  = '{16'd140,          2'b00};
    tbl[4]  = '{pix(3, 7, 28),    2'b01};
    tbl[5]  = '{pix(4, 7, 28),    2'b00};
    tbl[6]  = '{pix(0, 0, 27),    2'b00};
    tbl[7]  = '{pix(10, 30, 26),  2'b10};
    tbl[8]  = '{pix(14, 40, 31),  2'b10};
    tbl[9]  = '{pix(14, 41, 31),  2'b00};
    tbl[10] = '{pix(9, 30, 26),   2'b00};
    tbl[11] = '{16'h0000,         2'b00};

    rst             = 1'b1;
    per_frame_vsync = 1'b0;
    per_frame_href  = 1'b0;
    per_frame_clken = 1'b0;
    img_data        = '0;
    cfg_thr         = {c1_thr, c0_thr};
    cfg_min_pix     = 20'd16;
    model_reset();
    repeat (3) tick();
    check_outs("reset");
    check("reset_valid", 32'(color_valid), 32'd0);
    check("reset_post_hit", 32'(post_pix_hit), 32'd0);
    rst = 1'b0;
    tick();

    // Pixel-level table
    boundary();
    drive_cycle(1'b0, 1'b0, 1'b0, 16'h0);
    for (int i = 0; i < 12; i++) begin
      drive_cycle(1'b0, 1'b1, 1'b1, tbl[i].pix);
      check($sformatf("table_%0d", i), 32'(post_pix_hit), 32'(tbl[i].hit));
    end
    drive_cycle(1'b0, 1'b0, 1'b0, 16'h0);
    boundary();

    // Solid blue frames and confirmation
    rst = 1'b1;
    tick();
    rst = 1'b0;
    model_reset();
    tick();
    boundary();
    for (int k = 0; k < 4; k++) begin
      fill(16'h001F, 32);
      run_frame(1'b0, '0, '0);
      boundary();
      if (k == 0) begin
        check("solid_b2_hit", 32'(color_hit), 32'd1);
        check("solid_b2_conf", 32'(color_conf), 32'd0);
      end
      if (k == 2) begin
        check("solid_b4_conf", 32'(color_conf), 32'd1);
        check("solid_b4_img_en", 32'(img_en), 32'd1);
      end
    end

    // Colour-1 frame with two non-matching pixels
    fill(pix(12, 37, 29), 30);
    fq.push_back(16'd100);
    fq.push_back(16'd140);
    run_frame(1'b0, '0, '0);
    boundary();
    check("c1_hit", 32'(color_hit), 32'd2);
    check("c1_conf", 32'(color_conf), 32'd0);
    check("c1_dom_idx", 32'(dom_idx), DOM_EN ? 32'd1 : 32'd0);
    check("c1_dom_valid", 32'(dom_valid), DOM_EN ? 32'd1 : 32'd0);

    // Threshold boundary: 15 misses, 16 hits
    fill(16'h001F, 15);
    fill(16'h0000, 17);
    run_frame(1'b0, '0, '0);
    boundary();
    check("cnt15_hit", 32'(color_hit), 32'd0);
    fill(16'h001F, 16);
    fill(16'h0000, 16);
    run_frame(1'b0, '0, '0);
    boundary();
    check("cnt16_hit", 32'(color_hit), 32'd1);

    // cfg_min_pix changed mid-frame
    fill(16'h001F, 20);
    fill(16'h0000, 12);
    run_frame(1'b1, 20'd40, cfg_thr);
    boundary();
    check("midcfg_same_frame_hit", 32'(color_hit), 32'd1);
    fill(16'h001F, 20);
    fill(16'h0000, 12);
    run_frame(1'b0, '0, '0);
    boundary();
    check("midcfg_next_frame_hit", 32'(color_hit), 32'd0);
    cfg_min_pix = 20'd16;

    // Reset mid-frame after hit frames
    for (int k = 0; k < 3; k++) begin
      fill(16'h001F, 32);
      run_frame(1'b0, '0, '0);
      boundary();
    end
    check("prereset_hit", 32'(color_hit), 32'd1);
    drive_cycle(1'b0, 1'b0, 1'b0, 16'h0);
    for (int i = 0; i < 10; i++) drive_cycle(1'b0, 1'b1, 1'b1, 16'h001F);
    rst = 1'b1;
    #2;
    check("rst_color_hit", 32'(color_hit), 32'd0);
    check("rst_color_conf", 32'(color_conf), 32'd0);
    check("rst_img_en", 32'(img_en), 32'd0);
    check("rst_post_hit", 32'(post_pix_hit), 32'd0);
    check("rst_dom", 32'({dom_idx, dom_valid, color_valid}), 32'd0);
    per_frame_href  = 1'b0;
    per_frame_clken = 1'b0;
    tick();
    rst = 1'b0;
    model_reset();
    tick();
    boundary();
    fill(16'h001F, 32);
    run_frame(1'b0, '0, '0);
    boundary();
    check("postrst_hit", 32'(color_hit), 32'd1);

    // Equal counts: tie resolves to lowest index
    fill(16'h001F, 10);
    fill(pix(12, 37, 29), 10);
    fill(16'h0000, 12);
    run_frame(1'b0, '0, '0);
    boundary();
    check("tie_dom_idx", 32'(dom_idx), 32'd0);
    check("tie_dom_valid", 32'(dom_valid), DOM_EN ? 32'd1 : 32'd0);
    check("tie_hit", 32'(color_hit), 32'd0);

    // Randomised frames against the model
    for (int f = 0; f < 25; f++) begin
      bit               chg;
      logic [NC*32-1:0] nthr;
      int               n;
      cfg_min_pix = 20'($urandom_range(0, 30));
      n = 32 + int'($urandom_range(0, 8));
      for (int i = 0; i < n; i++) begin
        case ($urandom_range(0, 2))
          0: fq.push_back(16'($urandom));
          1: fq.push_back(pix($urandom_range(0, 3), $urandom_range(0, 7), $urandom_range(28, 31)));
          default: fq.push_back(pix($urandom_range(10, 14), $urandom_range(30, 40), $urandom_range(26, 31)));
        endcase
      end
      chg  = ($urandom_range(0, 3) == 0);
      nthr = (f % 2 == 0) ? {c1_thr, c0_thr}
                          : {mk_thr($urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 63),
                                    $urandom_range(0, 63), $urandom_range(0, 31), $urandom_range(0, 31)),
                             mk_thr($urandom_range(0, 8), $urandom_range(4, 31), $urandom_range(0, 20),
                                    $urandom_range(10, 63), $urandom_range(0, 20), $urandom_range(20, 31))};
      run_frame(chg, 20'($urandom_range(0, 30)), nthr);
      if (!chg && $urandom_range(0, 1) == 1) cfg_thr = nthr;
      boundary();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
